// File: rtl/free_list_arbiter.sv
// Front end for the physical-register free list: round-robin allocation grants,
// a small retire-side free queue, and rollback sequencing that keeps the ports quiet.
module free_list_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int NUM_FREE = 2,
  parameter int FQ_DEPTH = 4,
  parameter int PR_W     = 6,
  parameter int PR_SZ    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         alloc_req,
  output logic [NUM_REQ-1:0]         alloc_gnt,
  output logic [PR_W-1:0]            alloc_pr,
  input  logic [NUM_FREE-1:0]        free_valid,
  input  logic [NUM_FREE*PR_W-1:0]   free_pr,
  output logic                       free_ready,
  input  logic                       rollback_in,
  input  logic [PR_SZ-1:0]           rollback_mask_in,
  input  logic                       fl_is_empty,
  input  logic [PR_W-1:0]            fl_dequeue_pr,
  output logic                       fl_dequeue_en,
  output logic                       fl_enqueue_en,
  output logic [PR_W-1:0]            fl_enqueue_pr,
  output logic                       fl_rollback,
  output logic [PR_SZ-1:0]           fl_rollback_mask,
  output logic                       busy,
  output logic [$clog2(FQ_DEPTH):0]  fq_count
);

  localparam int PTR_W = $clog2(FQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {ST_RUN, ST_RB} state_t;

  state_t            r_state;
  logic [PR_SZ-1:0]  r_mask;
  logic [RR_W-1:0]   r_rr;
  logic [PR_W-1:0]   r_fq [FQ_DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_active;
  logic              w_avail;
  logic              w_grant_any;
  logic [RR_W-1:0]   w_gnt_idx;
  logic [RR_W-1:0]   w_idx;
  logic [CNT_W-1:0]  w_push_cnt;
  logic [PTR_W-1:0]  w_slot [NUM_FREE];

  // Enqueue and grant are both suppressed whenever a rollback is requested or in flight.
  assign w_active         = (r_state == ST_RUN) && !rollback_in;
  assign fl_enqueue_en    = w_active && (r_count != '0);
  assign fl_enqueue_pr    = r_fq[r_rd_ptr];
  assign w_avail          = !fl_is_empty || fl_enqueue_en;
  assign alloc_pr         = fl_dequeue_pr;
  assign fl_dequeue_en    = w_grant_any;
  assign free_ready       = (r_count <= CNT_W'(FQ_DEPTH - NUM_FREE));
  assign fq_count         = r_count;
  assign fl_rollback      = (r_state == ST_RB);
  assign busy             = (r_state == ST_RB);
  assign fl_rollback_mask = r_mask;

  always_comb begin
    alloc_gnt   = '0;
    w_gnt_idx   = '0;
    w_idx       = '0;
    w_grant_any = 1'b0;
    if (w_active && w_avail) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        w_idx = RR_W'((int'(r_rr) + k) % NUM_REQ);
        if (!w_grant_any && alloc_req[w_idx]) begin
          w_grant_any      = 1'b1;
          w_gnt_idx        = w_idx;
          alloc_gnt[w_idx] = 1'b1;
        end
      end
    end
  end

  // Valid frees are compacted: each lands at the write pointer plus the number of valid lower sources.
  always_comb begin
    w_push_cnt = '0;
    for (int i = 0; i < NUM_FREE; i++) begin
      w_slot[i] = r_wr_ptr + w_push_cnt[PTR_W-1:0];
      if (free_valid[i]) w_push_cnt = w_push_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_RUN;
      r_mask   <= '0;
      r_rr     <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (rollback_in) begin
            r_state <= ST_RB;
            r_mask  <= rollback_mask_in;
          end
        end
        ST_RB: begin
          if (rollback_in) begin
            r_mask <= r_mask | rollback_mask_in;
          end else begin
            r_state <= ST_RUN;
            r_mask  <= '0;
          end
        end
      endcase
      if (w_grant_any) r_rr <= RR_W'((int'(w_gnt_idx) + 1) % NUM_REQ);
      if (fl_enqueue_en) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (free_ready) r_wr_ptr <= r_wr_ptr + w_push_cnt[PTR_W-1:0];
      r_count <= r_count + (free_ready ? w_push_cnt : '0) - CNT_W'(fl_enqueue_en);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FREE; i++) begin
      if (free_ready && free_valid[i]) r_fq[w_slot[i]] <= free_pr[i*PR_W +: PR_W];
    end
  end

endmodule

// File: tb/tb_free_list_arbiter.sv
// Scoreboard bench for free_list_arbiter: a queue-based reference model predicts each cycle's
// outputs, and an independent monitor compares them on the falling edge.
module tb_free_list_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  alloc_req;
  logic [1:0]  alloc_gnt;
  logic [5:0]  alloc_pr;
  logic [1:0]  free_valid;
  logic [11:0] free_pr;
  logic        free_ready;
  logic        rollback_in;
  logic [31:0] rollback_mask_in;
  logic        fl_is_empty;
  logic [5:0]  fl_dequeue_pr;
  logic        fl_dequeue_en;
  logic        fl_enqueue_en;
  logic [5:0]  fl_enqueue_pr;
  logic        fl_rollback;
  logic [31:0] fl_rollback_mask;
  logic        busy;
  logic [2:0]  fq_count;

  free_list_arbiter dut (
    .clk(clk), .reset(reset),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_pr(alloc_pr),
    .free_valid(free_valid), .free_pr(free_pr), .free_ready(free_ready),
    .rollback_in(rollback_in), .rollback_mask_in(rollback_mask_in),
    .fl_is_empty(fl_is_empty), .fl_dequeue_pr(fl_dequeue_pr),
    .fl_dequeue_en(fl_dequeue_en), .fl_enqueue_en(fl_enqueue_en),
    .fl_enqueue_pr(fl_enqueue_pr), .fl_rollback(fl_rollback),
    .fl_rollback_mask(fl_rollback_mask), .busy(busy), .fq_count(fq_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  gnt;
    logic [5:0]  pr;
    logic        enqEn;
    logic [5:0]  enqPr;
    logic        rb;
    logic [31:0] mask;
    logic [2:0]  cnt;
    logic        ready;
  } expT;

  expT        expQ[$];
  logic [5:0] modelFq[$];
  int         modelRr;
  bit         modelInRb;
  logic [31:0] modelMask;
  logic [1:0] lastGnt;
  logic [1:0] pending;
  int         checks = 0;
  int         errors = 0;

  function automatic void checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void modelReset();
    modelFq.delete();
    modelRr   = 0;
    modelInRb = 1'b0;
    modelMask = '0;
    pending   = '0;
  endfunction

  // Predict this cycle's outputs from the abstract model, queue them, then advance the model one edge.
  task automatic applyStimulus();
    expT e;
    int  n;
    int  idx;
    bit  active;
    n        = modelFq.size();
    e.ready  = (4 - n) >= 2;
    e.cnt    = 3'(n);
    e.rb     = modelInRb;
    e.mask   = modelInRb ? modelMask : 32'h0;
    active   = !modelInRb && !rollback_in;
    e.enqEn  = active && (n > 0);
    e.enqPr  = e.enqEn ? modelFq[0] : 6'h0;
    e.gnt    = '0;
    e.pr     = fl_dequeue_pr;
    if (active && (!fl_is_empty || e.enqEn)) begin
      for (int k = 0; k < 2; k++) begin
        idx = (modelRr + k) % 2;
        if (e.gnt == 2'b00 && alloc_req[idx]) begin
          e.gnt[idx] = 1'b1;
          modelRr    = (idx + 1) % 2;
        end
      end
    end
    expQ.push_back(e);
    lastGnt = e.gnt;
    if (e.enqEn) void'(modelFq.pop_front());
    if (e.ready) begin
      for (int i = 0; i < 2; i++)
        if (free_valid[i]) modelFq.push_back(free_pr[i*6 +: 6]);
    end
    if (!modelInRb && rollback_in) begin
      modelInRb = 1'b1;
      modelMask = rollback_mask_in;
    end else if (modelInRb) begin
      if (rollback_in) modelMask = modelMask | rollback_mask_in;
      else begin
        modelInRb = 1'b0;
        modelMask = '0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    modelReset();
  endtask

  task automatic idleInputs();
    alloc_req        = '0;
    free_valid       = '0;
    free_pr          = '0;
    rollback_in      = 1'b0;
    rollback_mask_in = '0;
    fl_is_empty      = 1'b1;
    fl_dequeue_pr    = '0;
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      expT e;
      e = expQ.pop_front();
      checkOutput("free_ready", 32'(free_ready), 32'(e.ready));
      checkOutput("fq_count", 32'(fq_count), 32'(e.cnt));
      checkOutput("fl_rollback", 32'(fl_rollback), 32'(e.rb));
      checkOutput("busy", 32'(busy), 32'(e.rb));
      checkOutput("fl_rollback_mask", fl_rollback_mask, e.mask);
      checkOutput("fl_enqueue_en", 32'(fl_enqueue_en), 32'(e.enqEn));
      if (e.enqEn) checkOutput("fl_enqueue_pr", 32'(fl_enqueue_pr), 32'(e.enqPr));
      checkOutput("alloc_gnt", 32'(alloc_gnt), 32'(e.gnt));
      checkOutput("fl_dequeue_en", 32'(fl_dequeue_en), 32'(e.gnt != 2'b00));
      if (e.gnt != 2'b00) checkOutput("alloc_pr", 32'(alloc_pr), 32'(e.pr));
    end
  end

  initial begin
    idleInputs();
    reset = 1'b1;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Round-robin alternation with a non-empty free list
    fl_is_empty = 1'b0; fl_dequeue_pr = 6'd5; alloc_req = 2'b11;
    #1 checkOutput("tp_rst_ready", 32'(free_ready), 32'd1);
    checkOutput("tp_rr0", 32'(alloc_gnt), 32'b01);
    applyStimulus();
    #1 checkOutput("tp_rr1", 32'(alloc_gnt), 32'b10);
    applyStimulus();
    #1 checkOutput("tp_rr2", 32'(alloc_gnt), 32'b01);
    checkOutput("tp_rr2_pr", 32'(alloc_pr), 32'd5);
    applyStimulus();

    // Empty free list: grant only once a queued free passes through
    fl_is_empty = 1'b1; alloc_req = 2'b01; fl_dequeue_pr = 6'd0;
    #1 checkOutput("tp_empty_nognt", 32'(alloc_gnt), 32'b00);
    applyStimulus();
    free_valid = 2'b01; free_pr = {6'd0, 6'd9};
    applyStimulus();
    free_valid = 2'b00; fl_dequeue_pr = 6'd9;
    #1 checkOutput("tp_pass_enq", 32'(fl_enqueue_pr), 32'd9);
    checkOutput("tp_pass_gnt", 32'(alloc_gnt), 32'b01);
    applyStimulus();
    alloc_req = 2'b00;

    // Fill the queue while rollback blocks the enqueue port
    rollback_in = 1'b1; rollback_mask_in = 32'h0001_0000;
    free_valid = 2'b11; free_pr = {6'd8, 6'd7};
    repeat (2) applyStimulus();
    #1 checkOutput("tp_full_cnt", 32'(fq_count), 32'd4);
    checkOutput("tp_full_ready", 32'(free_ready), 32'd0);
    repeat (2) applyStimulus();
    rollback_in = 1'b0; free_valid = 2'b00;
    applyStimulus();
    #1 checkOutput("tp_drain0", 32'(fl_enqueue_pr), 32'd7);
    applyStimulus();
    #1 checkOutput("tp_drain1", 32'(fl_enqueue_pr), 32'd8);
    repeat (3) applyStimulus();

    // Single-cycle rollback blocks grants for two cycles
    fl_is_empty = 1'b0; fl_dequeue_pr = 6'd12; alloc_req = 2'b01;
    rollback_in = 1'b1; rollback_mask_in = 32'h0000_00F0;
    applyStimulus();
    rollback_in = 1'b0;
    #1 checkOutput("tp_rb_mask", fl_rollback_mask, 32'hF0);
    checkOutput("tp_rb_nognt", 32'(alloc_gnt), 32'b00);
    applyStimulus();
    #1 checkOutput("tp_rb_regnt", 32'(alloc_gnt), 32'b01);
    applyStimulus();
    alloc_req = 2'b00;

    // Back-to-back rollback merges masks
    rollback_in = 1'b1; rollback_mask_in = 32'h1;
    applyStimulus();
    rollback_mask_in = 32'h2;
    applyStimulus();
    rollback_in = 1'b0;
    #1 checkOutput("tp_rb_merge", fl_rollback_mask, 32'h3);
    repeat (2) applyStimulus();

    // Reset in the middle of a rollback with three queued frees
    rollback_in = 1'b1; rollback_mask_in = 32'h0002_0000;
    free_valid = 2'b11; free_pr = {6'd3, 6'd2};
    applyStimulus();
    free_valid = 2'b01; free_pr = {6'd0, 6'd4};
    applyStimulus();
    free_valid = 2'b00;
    #1 checkOutput("tp_pre_rst_cnt", 32'(fq_count), 32'd3);
    doReset();
    idleInputs();
    #1 checkOutput("tp_rst_cnt", 32'(fq_count), 32'd0);
    checkOutput("tp_rst_busy", 32'(busy), 32'd0);
    checkOutput("tp_rst_rbmask", fl_rollback_mask, 32'h0);
    checkOutput("tp_rst_enq", 32'(fl_enqueue_en), 32'd0);
    applyStimulus();

    // Randomised traffic against the reference model
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) == 0) begin
        doReset();
        continue;
      end
      pending          = pending | 2'($urandom_range(0, 3));
      alloc_req        = pending;
      fl_is_empty      = ($urandom_range(0, 2) == 0);
      fl_dequeue_pr    = (fl_is_empty && modelFq.size() > 0) ? modelFq[0] : 6'($urandom_range(0, 31));
      free_valid       = 2'($urandom_range(0, 3));
      free_pr          = {6'($urandom_range(0, 15)), 6'($urandom_range(0, 15))};
      rollback_in      = ($urandom_range(0, 7) == 0);
      rollback_mask_in = $urandom & 32'hFFFF_0000;
      applyStimulus();
      pending = pending & ~lastGnt;
    end

    idleInputs();
    @(negedge clk);
    #1 checkOutput("sb_drain", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
